// File: rtl/mips_pipe_pkg.sv
// Shared types and defaults for the MIPS pipeline memory-port arbiter.
package mips_pipe_pkg;

  localparam int unsigned DEF_MEM_LAT    = 2;
  localparam int unsigned DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
  typedef enum logic {OWN_IF, OWN_DM} ownerT;

endpackage

// File: rtl/arb_priority.sv
// Fetch/data grant selection: data wins by default, fetch wins once it has
// waited through STARVE_MAX consecutive data grants.
module arb_priority
  import mips_pipe_pkg::*;
#(
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  ifReq,
  input  logic  dmReq,
  input  logic  issue,
  output ownerT grant
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starveCnt;

  always_comb begin
    grant = OWN_IF;
    if (dmReq && (!ifReq || (starveCnt < STARVE_LIM))) grant = OWN_DM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starveCnt <= '0;
    end else if (issue) begin
      if ((grant == OWN_IF) || !ifReq) starveCnt <= '0;
      else if (starveCnt < STARVE_LIM) starveCnt <= starveCnt + 4'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access:
// issue in IDLE, wait MEM_LAT cycles, pulse the owner's done in RESP.
module mem_port_arbiter
  import mips_pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = DEF_MEM_LAT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [DATA_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              hold_if,
  output logic              hold_mem,
  output logic              busy
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  stateT      state;
  ownerT      owner;
  ownerT      grant;
  logic       ownerWe;
  logic [2:0] latCnt;
  logic       issue;

  // Gating with reset keeps the strobe quiet while reset is held, so the
  // first real issue lands on the first edge that sees reset released.
  assign issue = reset && (state == IDLE) && (if_req || dm_req);

  arb_priority #(
    .STARVE_MAX(STARVE_MAX)
  ) uArb (
    .clk  (clk),
    .reset(reset),
    .ifReq(if_req),
    .dmReq(dm_req),
    .issue(issue),
    .grant(grant)
  );

  always_comb begin
    mem_en    = issue;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (issue) begin
      if (grant == OWN_DM) begin
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else begin
        mem_addr = if_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      latCnt   <= '0;
      owner    <= OWN_IF;
      ownerWe  <= 1'b0;
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_done <= 1'b0;
      dm_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue) begin
            state   <= WAIT;
            owner   <= grant;
            ownerWe <= (grant == OWN_DM) && dm_we;
            latCnt  <= 3'd1;
          end
        end
        WAIT: begin
          if (latCnt == LAT) begin
            latCnt <= '0;
            state  <= RESP;
            if (owner == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_done  <= 1'b1;
            end else begin
              if (!ownerWe) dm_rdata <= mem_rdata;
              dm_done <= 1'b1;
            end
          end else begin
            latCnt <= latCnt + 3'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign hold_if  = if_req & ~if_done;
  assign hold_mem = dm_req & ~dm_done;
  assign busy     = (state != IDLE);

endmodule
